// File: rtl/carregador_pkg.sv
// Shared types and constants for the program loader (carregador_programa).
package carregador_pkg;
   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
   localparam int         CNT_W        = 16;
   localparam int         WORD_W       = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA,
      ST_CHECK,
      ST_DONE,
      ST_ERR
   } state_t;
endpackage

// File: rtl/carregador_programa_montador.sv
// montador_palavra: shifts stream bytes MSB-first into 32-bit words and flags the 4th byte.
module montador_palavra
   import carregador_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        data_byte,
   input  logic              strobe,
   input  logic              clear,
   output logic [WORD_W-1:0] word,
   output logic              word_ready
);
   logic [1:0]          byte_idx;
   logic [WORD_W-9:0]   partial;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         byte_idx <= 2'd0;
         partial  <= '0;
      end else if (strobe) begin
         byte_idx <= byte_idx + 2'd1;
         partial  <= {partial[WORD_W-17:0], data_byte};
      end
   end

   // Word and pulse are combinational so the top can register the write one edge later.
   assign word       = {partial, data_byte};
   assign word_ready = strobe && (byte_idx == 2'd3);
endmodule

// File: rtl/carregador_programa.sv
// Program loader: framed byte stream -> program memory write port, holds the CPU until loaded.
// Optional trailing XOR checksum byte enabled by defining CARREGADOR_CHECKSUM_EN.
//
// state     | meaning
// ST_IDLE   | waiting for SYNC_BYTE, other bytes dropped
// ST_LEN_HI | expecting word count MSB
// ST_LEN_LO | expecting word count LSB, range check
// ST_DATA   | assembling and writing words
// ST_CHECK  | expecting checksum byte (checksum build only)
// ST_DONE   | image loaded, CPU released, SYNC_BYTE restarts
// ST_ERR    | frame rejected, stuck until reset
module carregador_programa
   import carregador_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'd0,
   parameter int unsigned DEPTH     = 256,
   parameter logic [7:0]  SYNC_BYTE = SYNC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [WORD_W-1:0] mem_data,
   output logic [31:0]       mem_addr,
   output logic              mem_we,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);
   state_t             state;
   logic [7:0]         len_hi;
   logic [CNT_W-1:0]   words_left;
   logic [31:0]        wr_addr;
   logic               accept;
   logic               is_sync;
   logic               word_ready;
   logic [WORD_W-1:0]  word;
   logic [CNT_W-1:0]   len_word;
`ifdef CARREGADOR_CHECKSUM_EN
   logic [7:0]         csum;
`endif

   assign in_ready = rst_n && (state != ST_ERR);
   assign accept   = in_valid && in_ready;
   assign is_sync  = (in_data == SYNC_BYTE);
   assign len_word = {len_hi, in_data};

   montador_palavra u_montador (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_byte  (in_data),
      .strobe     (accept && (state == ST_DATA)),
      .clear      (accept && is_sync && ((state == ST_IDLE) || (state == ST_DONE))),
      .word       (word),
      .word_ready (word_ready)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         len_hi     <= 8'd0;
         words_left <= '0;
         wr_addr    <= BASE_ADDR;
         mem_we     <= 1'b0;
         mem_data   <= '0;
         mem_addr   <= BASE_ADDR;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
`ifdef CARREGADOR_CHECKSUM_EN
         csum       <= 8'd0;
`endif
      end else begin
         mem_we <= 1'b0;
         if (word_ready) begin
            mem_we   <= 1'b1;
            mem_data <= word;
            mem_addr <= wr_addr;
            wr_addr  <= wr_addr + 32'd1;
         end
         case (state)
            ST_IDLE: begin
               if (accept && is_sync) begin
                  state   <= ST_LEN_HI;
                  wr_addr <= BASE_ADDR;
`ifdef CARREGADOR_CHECKSUM_EN
                  csum    <= 8'd0;
`endif
               end
            end
            ST_LEN_HI: begin
               if (accept) begin
                  len_hi <= in_data;
                  state  <= ST_LEN_LO;
               end
            end
            ST_LEN_LO: begin
               if (accept) begin
                  if ({16'd0, len_word} > DEPTH) begin
                     state <= ST_ERR;
                     error <= 1'b1;
                  end else if (len_word == '0) begin
`ifdef CARREGADOR_CHECKSUM_EN
                     state    <= ST_CHECK;
`else
                     state    <= ST_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
`endif
                  end else begin
                     words_left <= len_word;
                     state      <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
`ifdef CARREGADOR_CHECKSUM_EN
               if (accept)
                  csum <= csum ^ in_data;
`endif
               if (word_ready) begin
                  words_left <= words_left - 1'b1;
                  if (words_left == 16'd1) begin
`ifdef CARREGADOR_CHECKSUM_EN
                     state    <= ST_CHECK;
`else
                     state    <= ST_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
`endif
                  end
               end
            end
`ifdef CARREGADOR_CHECKSUM_EN
            ST_CHECK: begin
               if (accept) begin
                  if (in_data == csum) begin
                     state    <= ST_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state <= ST_ERR;
                     error <= 1'b1;
                  end
               end
            end
`endif
            ST_DONE: begin
               // A new sync byte restarts the load from the base address.
               if (accept && is_sync) begin
                  state    <= ST_LEN_HI;
                  done     <= 1'b0;
                  cpu_hold <= 1'b1;
                  wr_addr  <= BASE_ADDR;
                  mem_addr <= BASE_ADDR;
`ifdef CARREGADOR_CHECKSUM_EN
                  csum     <= 8'd0;
`endif
               end
            end
            ST_ERR: begin
               state <= ST_ERR;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_carregador_programa.sv
// Directed self-checking bench for carregador_programa (either build of CARREGADOR_CHECKSUM_EN).
module tb_carregador_programa;
   localparam logic [31:0] BASE = 32'd4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] mem_data;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic        cpu_hold;
   logic        done;
   logic        error;

   int errors = 0;
   int checks = 0;

   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];

   carregador_programa #(.BASE_ADDR(BASE), .DEPTH(256), .SYNC_BYTE(8'hA5)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .mem_data (mem_data),
      .mem_addr (mem_addr),
      .mem_we   (mem_we),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we) begin
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_data);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic end_frame(input logic [7:0] c);
`ifdef CARREGADOR_CHECKSUM_EN
      send_byte(c);
`else
      if (c === 8'hxx) $display("unused checksum");
`endif
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   initial begin
      logic [7:0]  big_csum;
      logic [31:0] w;
      logic        seq_ok;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_data", mem_data, 32'd0);
      check("rst_mem_addr", mem_addr, BASE);
      check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("ready_after_rst", {31'd0, in_ready}, 32'd1);

      // Two-word frame, back-to-back bytes
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
      send_word(32'h12345678);
      send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE);
      check("mid_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      check("mid_done", {31'd0, done}, 32'd0);
      send_byte(8'hF0);
`ifndef CARREGADOR_CHECKSUM_EN
      check("last_we_with_done", {31'd0, mem_we}, 32'd1);
      check("last_addr", mem_addr, BASE + 32'd1);
      check("last_data", mem_data, 32'h9ABCDEF0);
`endif
      end_frame(8'h00);
      check("a_done", {31'd0, done}, 32'd1);
      check("a_cpu_hold", {31'd0, cpu_hold}, 32'd0);
      idle(2);
      check("a_nwrites", wr_addr_q.size(), 32'd2);
      if (wr_addr_q.size() == 2) begin
         check("a_addr0", wr_addr_q[0], BASE);
         check("a_data0", wr_data_q[0], 32'h12345678);
         check("a_addr1", wr_addr_q[1], BASE + 32'd1);
         check("a_data1", wr_data_q[1], 32'h9ABCDEF0);
      end
      check("a_we_pulse", {31'd0, mem_we}, 32'd0);

      // Reload from DONE; stray byte first is ignored
      wr_addr_q.delete(); wr_data_q.delete();
      send_byte(8'h00);
      check("done_ignores", {31'd0, done}, 32'd1);
      send_byte(8'hA5);
      check("reload_hold", {31'd0, cpu_hold}, 32'd1);
      check("reload_done", {31'd0, done}, 32'd0);
      check("reload_addr", mem_addr, BASE);
      send_byte(8'h00); send_byte(8'h01);
      send_word(32'hAABBCCDD);
      end_frame(8'h00);
      check("reload_done2", {31'd0, done}, 32'd1);
      idle(2);
      check("reload_nwrites", wr_addr_q.size(), 32'd1);
      if (wr_addr_q.size() == 1) begin
         check("reload_waddr", wr_addr_q[0], BASE);
         check("reload_wdata", wr_data_q[0], 32'hAABBCCDD);
      end

      // Leading junk before sync
      do_reset();
      send_byte(8'h00); send_byte(8'hFF);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
      send_word(32'h11223344);
      end_frame(8'h44);
      check("junk_done", {31'd0, done}, 32'd1);
      idle(2);
      check("junk_nwrites", wr_addr_q.size(), 32'd1);
      if (wr_addr_q.size() == 1) begin
         check("junk_addr", wr_addr_q[0], BASE);
         check("junk_data", wr_data_q[0], 32'h11223344);
      end

      // Reset mid-frame, then a clean 1-word load
      do_reset();
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
      send_byte(8'hDE); send_byte(8'hAD);
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_ready", {31'd0, in_ready}, 32'd0);
      check("midrst_hold", {31'd0, cpu_hold}, 32'd1);
      rst_n = 1'b1;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
      send_word(32'h01020304);
      end_frame(8'h04);
      check("midrst_done", {31'd0, done}, 32'd1);
      idle(2);
      check("midrst_nwrites", wr_addr_q.size(), 32'd1);
      if (wr_addr_q.size() == 1) begin
         check("midrst_addr", wr_addr_q[0], BASE);
         check("midrst_data", wr_data_q[0], 32'h01020304);
      end

      // Empty image
      do_reset();
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
      end_frame(8'h00);
      check("n0_done", {31'd0, done}, 32'd1);
      check("n0_hold", {31'd0, cpu_hold}, 32'd0);
      idle(2);
      check("n0_nwrites", wr_addr_q.size(), 32'd0);

      // Full capacity, N = DEPTH
      do_reset();
      big_csum = 8'd0;
      seq_ok = 1'b1;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      for (int i = 0; i < 256; i++) begin
         for (int j = 0; j < 4; j++) begin
            w[31-8*j -: 8] = 8'(4 * i + j);
            big_csum = big_csum ^ 8'(4 * i + j);
         end
         send_word(w);
      end
      end_frame(big_csum);
      check("full_done", {31'd0, done}, 32'd1);
      check("full_error", {31'd0, error}, 32'd0);
      idle(2);
      check("full_nwrites", wr_addr_q.size(), 32'd256);
      for (int i = 0; i < wr_addr_q.size(); i++) begin
         for (int j = 0; j < 4; j++) w[31-8*j -: 8] = 8'(4 * i + j);
         if (wr_addr_q[i] !== BASE + 32'(i) || wr_data_q[i] !== w) seq_ok = 1'b0;
      end
      check("full_sequence", {31'd0, seq_ok}, 32'd1);

      // Oversized frame, N = DEPTH + 1
      do_reset();
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
      in_valid = 1'b0;
      check("ovf_error", {31'd0, error}, 32'd1);
      check("ovf_ready", {31'd0, in_ready}, 32'd0);
      check("ovf_hold", {31'd0, cpu_hold}, 32'd1);
      send_word(32'hA5000101);
      idle(2);
      check("ovf_sticky", {31'd0, error}, 32'd1);
      check("ovf_done", {31'd0, done}, 32'd0);
      check("ovf_nwrites", wr_addr_q.size(), 32'd0);

`ifdef CARREGADOR_CHECKSUM_EN
      // Bad checksum: write happens, then error
      do_reset();
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
      send_word(32'h01020304);
      end_frame(8'h05);
      check("bad_csum_error", {31'd0, error}, 32'd1);
      check("bad_csum_done", {31'd0, done}, 32'd0);
      check("bad_csum_hold", {31'd0, cpu_hold}, 32'd1);
      idle(2);
      check("bad_csum_nwrites", wr_addr_q.size(), 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
